// File: rtl/sram_param.sv
// sram_param: parametrised single-port synchronous SRAM with per-byte write
// enables, a registered read with a valid strobe, range/conflict error
// flagging and an optional post-reset clear sequencer.
module sram_param #(
    parameter int              DATA_W         = 8,
    parameter int              ADDR_W         = 8,
    parameter int              DEPTH          = 256,
    parameter int              CLEAR_ON_RESET = 1,
    parameter logic [DATA_W-1:0] CLEAR_VAL    = {DATA_W{1'b0}}
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic                CS,
    input  logic                WE,
    input  logic                RD,
    input  logic [DATA_W/8-1:0] BE,
    input  logic [ADDR_W-1:0]   Addr,
    input  logic [DATA_W-1:0]   dataIn,
    output logic [DATA_W-1:0]   dataOut,
    output logic                dataValid,
    output logic                Busy,
    output logic                Err
);

    localparam int NBYTES = DATA_W / 8;

    // Counter and range compare are one bit wider than the address so that
    // DEPTH = 2**ADDR_W is representable and the clear count never wraps.
    localparam logic [ADDR_W:0] DEPTH_W  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] LAST_W   = (ADDR_W + 1)'(DEPTH - 1);
    localparam logic            BUSY_RST = (CLEAR_ON_RESET != 0) ? 1'b1 : 1'b0;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    localparam state_t STATE_RST = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;

    logic [DATA_W-1:0] mem_r [DEPTH];

    state_t              state_r;
    state_t              state_next_s;
    logic [ADDR_W:0]     clr_cnt_r;
    logic [ADDR_W:0]     clr_cnt_next_s;
    logic                busy_r;
    logic [DATA_W-1:0]   dout_r;
    logic                valid_r;
    logic                err_r;

    logic                acc_s;
    logic                in_range_s;
    logic                wr_ok_s;
    logic                rd_ok_s;
    logic                rd_oor_s;
    logic                err_s;
    logic                clr_we_s;

    logic                mem_we_s;
    logic [ADDR_W-1:0]   mem_addr_s;
    logic [DATA_W-1:0]   mem_data_s;
    logic [NBYTES-1:0]   mem_be_s;

    // State register and clear counter; reset restarts the clear from word 0.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_r   <= STATE_RST;
            clr_cnt_r <= {(ADDR_W + 1){1'b0}};
            busy_r    <= BUSY_RST;
        end else begin
            state_r   <= state_next_s;
            clr_cnt_r <= clr_cnt_next_s;
            busy_r    <= (state_next_s == ST_CLEAR);
        end
    end

    // Next-state logic: step through every word once, then stay READY.
    always_comb begin
        state_next_s   = state_r;
        clr_cnt_next_s = clr_cnt_r;
        case (state_r)
            ST_CLEAR: begin
                if (clr_cnt_r == LAST_W) begin
                    state_next_s   = ST_READY;
                    clr_cnt_next_s = {(ADDR_W + 1){1'b0}};
                end else begin
                    state_next_s   = ST_CLEAR;
                    clr_cnt_next_s = clr_cnt_r + {{ADDR_W{1'b0}}, 1'b1};
                end
            end
            ST_READY: begin
                state_next_s   = ST_READY;
                clr_cnt_next_s = {(ADDR_W + 1){1'b0}};
            end
            default: begin
                state_next_s   = ST_READY;
                clr_cnt_next_s = {(ADDR_W + 1){1'b0}};
            end
        endcase
    end

    // Access decode: only a selected access in READY does anything.
    always_comb begin
        acc_s      = (state_r == ST_READY) && CS;
        in_range_s = ({1'b0, Addr} < DEPTH_W);
        wr_ok_s    = acc_s && WE && !RD && in_range_s;
        rd_ok_s    = acc_s && RD && !WE && in_range_s;
        rd_oor_s   = acc_s && RD && !WE && !in_range_s;
        err_s      = acc_s && ((WE && RD) || ((WE ^ RD) && !in_range_s));
        clr_we_s   = (state_r == ST_CLEAR) && !Rst;
    end

    // Memory write port mux: the clear sequencer owns the port while running.
    always_comb begin
        mem_we_s   = 1'b0;
        mem_addr_s = Addr;
        mem_data_s = dataIn;
        mem_be_s   = BE;
        if (clr_we_s) begin
            mem_we_s   = 1'b1;
            mem_addr_s = clr_cnt_r[ADDR_W-1:0];
            mem_data_s = CLEAR_VAL;
            mem_be_s   = {NBYTES{1'b1}};
        end else if (wr_ok_s) begin
            mem_we_s   = 1'b1;
        end else begin
            mem_we_s   = 1'b0;
        end
    end

    // Storage array: byte-granular write, contents are not reset.
    always_ff @(posedge Clk) begin
        if (mem_we_s) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (mem_be_s[i]) begin
                    mem_r[mem_addr_s][8*i +: 8] <= mem_data_s[8*i +: 8];
                end
            end
        end
    end

    // Registered read data and single-cycle status strobes.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            dout_r  <= {DATA_W{1'b0}};
            valid_r <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            if (rd_ok_s) begin
                dout_r <= mem_r[Addr];
            end else if (rd_oor_s) begin
                dout_r <= {DATA_W{1'b0}};
            end
            valid_r <= rd_ok_s;
            err_r   <= err_s;
        end
    end

    assign dataOut   = dout_r;
    assign dataValid = valid_r;
    assign Err       = err_r;
    assign Busy      = busy_r;

endmodule

// File: tb/tb_sram_param.sv
// tb_sram_param: directed, table-driven check of sram_param using three
// instances (8-bit/256 words, 32-bit byte-enabled, 8-bit/200 words).
module tb_sram_param;

    logic        Clk;
    logic        Rst;
    logic        cs_s;
    logic        we_s;
    logic        rd_s;
    logic [7:0]  addr_s;
    logic [31:0] din_s;
    logic [3:0]  be_s;

    logic [7:0]  dout8_s;
    logic        valid8_s, busy8_s, err8_s;
    logic [31:0] dout32_s;
    logic        valid32_s, busy32_s, err32_s;
    logic [7:0]  dout200_s;
    logic        valid200_s, busy200_s, err200_s;

    int n_vec  = 0;
    int n_miss = 0;

    sram_param #(.DATA_W(8), .ADDR_W(8), .DEPTH(256), .CLEAR_ON_RESET(1),
                 .CLEAR_VAL(8'hA5)) u_sram8 (
        .Clk(Clk), .Rst(Rst), .CS(cs_s), .WE(we_s), .RD(rd_s),
        .BE(be_s[0:0]), .Addr(addr_s), .dataIn(din_s[7:0]),
        .dataOut(dout8_s), .dataValid(valid8_s), .Busy(busy8_s), .Err(err8_s));

    sram_param #(.DATA_W(32), .ADDR_W(8), .DEPTH(256), .CLEAR_ON_RESET(1),
                 .CLEAR_VAL(32'hDEADBEEF)) u_sram32 (
        .Clk(Clk), .Rst(Rst), .CS(cs_s), .WE(we_s), .RD(rd_s),
        .BE(be_s), .Addr(addr_s), .dataIn(din_s),
        .dataOut(dout32_s), .dataValid(valid32_s), .Busy(busy32_s), .Err(err32_s));

    sram_param #(.DATA_W(8), .ADDR_W(8), .DEPTH(200), .CLEAR_ON_RESET(1),
                 .CLEAR_VAL(8'h5A)) u_sram200 (
        .Clk(Clk), .Rst(Rst), .CS(cs_s), .WE(we_s), .RD(rd_s),
        .BE(be_s[0:0]), .Addr(addr_s), .dataIn(din_s[7:0]),
        .dataOut(dout200_s), .dataValid(valid200_s), .Busy(busy200_s), .Err(err200_s));

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic        cs;
        logic        we;
        logic        rd;
        logic [7:0]  addr;
        logic [31:0] din;
        logic [3:0]  be;
        logic [1:0]  tgt;
        logic [31:0] exp_d;
        logic        exp_v;
        logic        exp_e;
    } vec_t;

    localparam int NV = 26;
    vec_t vt [NV];

    task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic cs, input logic we, input logic rd,
                         input logic [7:0] addr, input logic [31:0] din,
                         input logic [3:0] be);
        @(negedge Clk);
        cs_s = cs; we_s = we; rd_s = rd; addr_s = addr; din_s = din; be_s = be;
        @(posedge Clk);
        #1;
    endtask

    function automatic logic [39:0] pick(input logic [1:0] tgt);
        logic [39:0] r;
        case (tgt)
            2'd0:    r = {6'd0, valid8_s, err8_s, 24'd0, dout8_s};
            2'd1:    r = {6'd0, valid32_s, err32_s, dout32_s};
            default: r = {6'd0, valid200_s, err200_s, 24'd0, dout200_s};
        endcase
        return r;
    endfunction

    initial begin
        int n;
        int n200;
        string nm;

        // {cs, we, rd, addr, din, be, tgt, exp_d, exp_v, exp_e}
        vt[0]  = '{1'b1, 1'b0, 1'b1, 8'd0,   32'h0,        4'h1, 2'd0, 32'hA5,       1'b1, 1'b0};
        vt[1]  = '{1'b1, 1'b0, 1'b1, 8'd128, 32'h0,        4'h1, 2'd0, 32'hA5,       1'b1, 1'b0};
        vt[2]  = '{1'b1, 1'b0, 1'b1, 8'd255, 32'h0,        4'h1, 2'd0, 32'hA5,       1'b1, 1'b0};
        vt[3]  = '{1'b1, 1'b0, 1'b0, 8'd0,   32'h0,        4'h0, 2'd0, 32'hA5,       1'b0, 1'b0};
        vt[4]  = '{1'b1, 1'b1, 1'b0, 8'h10,  32'h3C,       4'h1, 2'd0, 32'hA5,       1'b0, 1'b0};
        vt[5]  = '{1'b1, 1'b0, 1'b1, 8'h10,  32'h0,        4'h1, 2'd0, 32'h3C,       1'b1, 1'b0};
        vt[6]  = '{1'b0, 1'b0, 1'b0, 8'd0,   32'h0,        4'h0, 2'd0, 32'h3C,       1'b0, 1'b0};
        vt[7]  = '{1'b0, 1'b1, 1'b0, 8'h10,  32'hFF,       4'h1, 2'd0, 32'h3C,       1'b0, 1'b0};
        vt[8]  = '{1'b1, 1'b0, 1'b1, 8'h10,  32'h0,        4'h1, 2'd0, 32'h3C,       1'b1, 1'b0};
        vt[9]  = '{1'b1, 1'b0, 1'b1, 8'd0,   32'h0,        4'h1, 2'd0, 32'hA5,       1'b1, 1'b0};
        vt[10] = '{1'b1, 1'b1, 1'b0, 8'd32,  32'h11223344, 4'hF, 2'd1, 32'hDEADBEEF, 1'b0, 1'b0};
        vt[11] = '{1'b1, 1'b1, 1'b0, 8'd32,  32'hAABBCCDD, 4'h5, 2'd1, 32'hDEADBEEF, 1'b0, 1'b0};
        vt[12] = '{1'b1, 1'b0, 1'b1, 8'd32,  32'h0,        4'h0, 2'd1, 32'h11BB33DD, 1'b1, 1'b0};
        vt[13] = '{1'b1, 1'b1, 1'b0, 8'd32,  32'hFFFFFFFF, 4'h0, 2'd1, 32'h11BB33DD, 1'b0, 1'b0};
        vt[14] = '{1'b1, 1'b0, 1'b1, 8'd32,  32'h0,        4'h0, 2'd1, 32'h11BB33DD, 1'b1, 1'b0};
        vt[15] = '{1'b1, 1'b1, 1'b0, 8'd5,   32'h66,       4'h1, 2'd2, 32'hDD,       1'b0, 1'b0};
        vt[16] = '{1'b1, 1'b0, 1'b1, 8'd5,   32'h0,        4'h1, 2'd2, 32'h66,       1'b1, 1'b0};
        vt[17] = '{1'b1, 1'b1, 1'b0, 8'd210, 32'h77,       4'h1, 2'd2, 32'h66,       1'b0, 1'b1};
        vt[18] = '{1'b1, 1'b0, 1'b1, 8'd210, 32'h0,        4'h1, 2'd2, 32'h00,       1'b0, 1'b1};
        vt[19] = '{1'b1, 1'b1, 1'b1, 8'd5,   32'h99,       4'h1, 2'd2, 32'h00,       1'b0, 1'b1};
        vt[20] = '{1'b1, 1'b0, 1'b1, 8'd5,   32'h0,        4'h1, 2'd2, 32'h66,       1'b1, 1'b0};
        vt[21] = '{1'b1, 1'b0, 1'b1, 8'd199, 32'h0,        4'h1, 2'd2, 32'h5A,       1'b1, 1'b0};
        vt[22] = '{1'b1, 1'b0, 1'b1, 8'd200, 32'h0,        4'h1, 2'd2, 32'h00,       1'b0, 1'b1};
        vt[23] = '{1'b1, 1'b0, 1'b0, 8'd0,   32'h0,        4'h1, 2'd2, 32'h00,       1'b0, 1'b0};
        vt[24] = '{1'b1, 1'b1, 1'b1, 8'h10,  32'hEE,       4'h1, 2'd0, 32'hA5,       1'b0, 1'b1};
        vt[25] = '{1'b1, 1'b0, 1'b1, 8'h10,  32'h0,        4'h1, 2'd0, 32'h3C,       1'b1, 1'b0};

        cs_s = 1'b0; we_s = 1'b0; rd_s = 1'b0; addr_s = 8'd0; din_s = 32'd0; be_s = 4'h0;
        Rst = 1'b0;
        #1 Rst = 1'b1;

        // Reset state
        repeat (3) @(posedge Clk);
        #1;
        chk("rst_out8", {6'd0, busy8_s, valid8_s, err8_s, 23'd0, dout8_s},
                        {6'd0, 1'b1, 1'b0, 1'b0, 23'd0, 8'h00});
        chk("rst_busy", {37'd0, busy8_s, busy32_s, busy200_s}, {37'd0, 3'b111});

        // Clear sequence with a write to word 0 held throughout (must be ignored)
        cs_s = 1'b1; we_s = 1'b1; rd_s = 1'b0; addr_s = 8'd0; din_s = 32'd0; be_s = 4'hF;
        @(negedge Clk);
        Rst = 1'b0;
        n = 0; n200 = 0;
        do begin
            @(posedge Clk);
            #1;
            n++;
            if (n200 == 0 && !busy200_s) n200 = n;
            if (valid8_s || err8_s) begin
                n_miss++;
                $display("FAIL busy_strobe: valid=%b err=%b at clear cycle %0d, expected 0", valid8_s, err8_s, n);
            end
        end while (busy8_s && n < 1000);
        chk("clear_len256", 40'(n), 40'd256);
        chk("clear_len200", 40'(n200), 40'd200);
        chk("busy32_done", {39'd0, busy32_s}, 40'd0);

        // Table of single-cycle accesses
        for (int i = 0; i < NV; i++) begin
            drive(vt[i].cs, vt[i].we, vt[i].rd, vt[i].addr, vt[i].din, vt[i].be);
            nm = $sformatf("vec%0d", i);
            chk(nm, pick(vt[i].tgt), {6'd0, vt[i].exp_v, vt[i].exp_e, vt[i].exp_d});
        end

        // Fill the 8-bit store with zeros so the re-clear is observable
        for (int a = 0; a < 256; a++) begin
            drive(1'b1, 1'b1, 1'b0, 8'(a), 32'h0, 4'hF);
        end
        drive(1'b1, 1'b0, 1'b1, 8'd77, 32'h0, 4'h1);
        chk("fill_zero", {31'd0, valid8_s, dout8_s}, {31'd0, 1'b1, 8'h00});

        // Reset, release, then reset again 100 cycles into the clear
        @(negedge Clk);
        cs_s = 1'b0; we_s = 1'b0; rd_s = 1'b0;
        Rst = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        chk("rst2_out", {30'd0, busy8_s, valid8_s, dout8_s}, {30'd0, 1'b1, 1'b0, 8'h00});
        @(negedge Clk);
        Rst = 1'b0;
        repeat (100) @(posedge Clk);
        #1;
        chk("busy_mid_clear", {39'd0, busy8_s}, 40'd1);
        @(negedge Clk);
        Rst = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        chk("busy_in_rst", {39'd0, busy8_s}, 40'd1);
        @(negedge Clk);
        Rst = 1'b0;
        n = 0;
        do begin
            @(posedge Clk);
            #1;
            n++;
        end while (busy8_s && n < 1000);
        chk("reclear_len", 40'(n), 40'd256);

        // Every word must hold the fill value; back-to-back reads keep valid high
        for (int a = 0; a < 256; a++) begin
            drive(1'b1, 1'b0, 1'b1, 8'(a), 32'h0, 4'h1);
            nm = $sformatf("reclear_w%0d", a);
            chk(nm, {31'd0, valid8_s, dout8_s}, {31'd0, 1'b1, 8'hA5});
        end
        drive(1'b0, 1'b0, 1'b0, 8'd0, 32'h0, 4'h0);
        chk("final_idle", {31'd0, valid8_s, dout8_s}, {31'd0, 1'b0, 8'hA5});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
